mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Two-port arbiter and sequencer for the single LC-3 memory array. It shares the array between the CPU port and a device/DMA port, such as keyboard/display or loader. It owns the memory-side MIO_EN, R_W, address and write data, waits for the memory ready handshake (R), and returns a one-cycle ready pulse plus registered read data to the granted requester. A cycle timeout aborts accesses that never see R.

Parameters:
TO_CYCLES, 15, max cycles in ACCESS before abort (1..255)
TO_W, 8, width of timeout counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
cpu_req  input  1  CPU access request, held until cpu_ready
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  16  CPU address
cpu_wdata  input  16  CPU write data
cpu_rdata  output  16  read data, valid when cpu_ready=1
cpu_ready  output  1  one-cycle completion pulse to CPU
dev_req  input  1  device access request, held until dev_ready
dev_we  input  1  1 = write
dev_addr  input  16  device address
dev_wdata  input  16  device write data
dev_rdata  output  16  read data, valid when dev_ready=1
dev_ready  output  1  one-cycle completion pulse to device
err  output  1  pulses with ready when the access timed out
grant  output  2  01 = CPU owns memory, 10 = device, 00 = idle
mem_en  output  1  MIO_EN to memory
mem_we  output  1  R_W to memory (1 = write)
mem_addr  output  16  memory address
mem_wdata  output  16  memory write data
mem_rdata  input  16  memory read data
mem_r  input  1  memory ready (R)

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; timeout counter 0; last-grant = device, so the CPU wins first under round-robin.
- FSM states are IDLE, ACCESS and DONE.
- IDLE:
  - Request inputs are sampled only in this state.
  - If any req is high, the arbiter latches owner, we, addr and wdata at the rising edge, then goes to ACCESS.
  - If no req is high, it stays in IDLE.
- ACCESS:
  - mem_en=1. mem_we, mem_addr and mem_wdata are driven from the latched values and stay stable for the whole state.
  - grant shows the owner.
  - The timeout counter increments each cycle.
  - If mem_r=1 at the edge: latch mem_rdata into the owner's rdata register on reads (unchanged on writes), then go to DONE with err=0.
  - If mem_r=0 and the count reaches TO_CYCLES: go to DONE with err=1 and rdata=16'h0000 on reads.
- DONE:
  - The owner's ready=1 for exactly one cycle; err is valid in the same cycle.
  - mem_en=0; grant stays on the owner. Next state is IDLE.
  - The counter is cleared.
- Latency: a req first seen at edge N gives mem_en high from cycle N+1. With mem_r already high, ready is high in cycle N+2. Minimum 3 cycles per access.
- Requesters must drop req in the cycle after ready. A req still high in the IDLE cycle after DONE is treated as a new access.
- Priority without the optional feature: fixed, CPU > device. With both reqs high in IDLE the CPU is granted; the device waits.
- Request inputs changing during ACCESS or DONE are ignored; the access in flight always completes, or times out.
- rdata outputs hold their last value until the next read completes for that port.
- Reset asserted mid-ACCESS: mem_en drops immediately (async), no ready pulse, state=IDLE.
- Non-owner ready is always 0. grant is one-hot or zero, never 11.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- When defined: on simultaneous requests in IDLE, the port not granted last wins. Last-grant updates on every grant. A lone request is always granted.
- When undefined: fixed CPU priority as above. The last-grant register is not built.

Test Plan:
- CPU read:
  - Stimulus: cpu_req=1, cpu_we=0, cpu_addr=16'h3000; memory returns 16'h1234 with mem_r=1 two cycles into ACCESS.
  - Required: mem_en=1 with mem_addr=3000 for 2 cycles; cpu_ready pulses once with cpu_rdata=1234, err=0; dev_ready stays 0.
- Device write:
  - Stimulus: dev_req=1, dev_we=1, dev_addr=16'hFE06, dev_wdata=16'h0041; mem_r=1 immediately.
  - Required: mem_we=1, mem_wdata=0041 during ACCESS; dev_ready high exactly 3 cycles after req; grant=10.
- Contention, fixed priority:
  - Stimulus: both reqs high at the same edge, held.
  - Required: CPU is served first, then the device; grant sequence 01, 01, 00, 10.
- Contention with MEM_ARB_ROUND_ROBIN_EN:
  - Stimulus: both reqs held for 4 accesses.
  - Required: grants alternate CPU, device, CPU, device.
- Timeout:
  - Stimulus: CPU read with mem_r held 0.
  - Required: after 15 ACCESS cycles, cpu_ready=1 and err=1 with cpu_rdata=0000; FSM back in IDLE the next cycle.
- Reset mid-access:
  - Stimulus: reset=0 during ACCESS.
  - Required: mem_en, grant and ready go to 0 asynchronously; after release with no reqs, the FSM stays IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (CPU / device) arbiter and sequencer for the single
// LC-3 memory array. Drives MIO_EN, R_W, address and write data, waits for
// the memory ready (R) handshake and returns a one-cycle ready pulse plus
// registered read data to the granted port. Accesses that never see R are
// aborted after TO_CYCLES cycles and flagged with err.
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN (round-robin between ports on
// simultaneous requests); when undefined the CPU has fixed priority.
module mem_arbiter #(
   parameter int unsigned TO_CYCLES = 15,
   parameter int unsigned TO_W      = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [15:0] cpu_addr,
   input  logic [15:0] cpu_wdata,
   output logic [15:0] cpu_rdata,
   output logic        cpu_ready,
   input  logic        dev_req,
   input  logic        dev_we,
   input  logic [15:0] dev_addr,
   input  logic [15:0] dev_wdata,
   output logic [15:0] dev_rdata,
   output logic        dev_ready,
   output logic        err,
   output logic [1:0]  grant,
   output logic        mem_en,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_r
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Last ACCESS cycle index: the counter starts at 0 on entry to ACCESS.
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

   state_t          state;
   state_t          state_nxt;
   logic            any_req;
   logic            owner_sel;   // 0 = CPU, 1 = device
   logic            owner_q;
   logic            we_q;
   logic [15:0]     addr_q;
   logic [15:0]     wdata_q;
   logic [15:0]     cpu_rdata_q;
   logic [15:0]     dev_rdata_q;
   logic [TO_W-1:0] cnt_q;
   logic            err_q;
   logic            timeout;

   assign any_req   = cpu_req | dev_req;
   assign cpu_rdata = cpu_rdata_q;
   assign dev_rdata = dev_rdata_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic last_q;   // port granted most recently, 0 = CPU, 1 = device

   // Owner choice: on a tie the port not granted last wins.
   always_comb begin
      owner_sel = 1'b0;
      if (cpu_req && dev_req) owner_sel = ~last_q;
      else if (dev_req)       owner_sel = 1'b1;
   end

   // Remember the last granted port; reset to device so the CPU wins first.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                      last_q <= 1'b1;
      else if (state == IDLE && any_req) last_q <= owner_sel;
   end
`else
   // Owner choice: fixed priority, CPU over device.
   always_comb begin
      owner_sel = ~cpu_req & dev_req;
   end
`endif

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode and memory/requester-facing outputs.
   always_comb begin
      state_nxt = state;
      timeout   = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      grant     = 2'b00;
      cpu_ready = 1'b0;
      dev_ready = 1'b0;
      err       = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) state_nxt = ACCESS;
         end
         ACCESS: begin
            mem_en    = 1'b1;
            mem_we    = we_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            grant     = owner_q ? 2'b10 : 2'b01;
            timeout   = !mem_r && (cnt_q == TO_LAST);
            if (mem_r || timeout) state_nxt = DONE;
         end
         DONE: begin
            grant     = owner_q ? 2'b10 : 2'b01;
            cpu_ready = ~owner_q;
            dev_ready = owner_q;
            err       = err_q;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request capture, timeout counter and per-port read data registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner_q     <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_rdata_q <= '0;
         dev_rdata_q <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cnt_q <= '0;
               err_q <= 1'b0;
               if (any_req) begin
                  owner_q <= owner_sel;
                  we_q    <= owner_sel ? dev_we    : cpu_we;
                  addr_q  <= owner_sel ? dev_addr  : cpu_addr;
                  wdata_q <= owner_sel ? dev_wdata : cpu_wdata;
               end
            end
            ACCESS: begin
               cnt_q <= cnt_q + TO_W'(1);
               if (mem_r) begin
                  err_q <= 1'b0;
                  if (!we_q) begin
                     if (owner_q) dev_rdata_q <= mem_rdata;
                     else         cpu_rdata_q <= mem_rdata;
                  end
               end else if (timeout) begin
                  err_q <= 1'b1;
                  if (!we_q) begin
                     if (owner_q) dev_rdata_q <= '0;
                     else         cpu_rdata_q <= '0;
                  end
               end
            end
            DONE: begin
               cnt_q <= '0;
            end
            default: begin
               cnt_q <= '0;
            end
         endcase
      end
   end

endmodule
